ddr_init_seq: RTL and testbench

//  Parametrised DDR1 power-up/initialisation sequencer; successor to the fixed-timing init FSM.

---
 rtl/ddr_init_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
// ddr_init_seq: parametrised DDR1 power-up / initialisation sequencer.
// Drives the DDR command bus from reset until init_done; all bus pins and CKE are registered.
// Optional feature macro: DDR_INIT_REINIT_EN adds reinit_req, which reruns the sequence from PRE0
// when pulsed in DONE. Without it DONE is terminal until reset.
module ddr_init_seq #(
   parameter int unsigned         ROW_BITS    = 13,
   parameter int unsigned         BA_BITS     = 2,
   parameter int unsigned         T_PWRUP_CYC = 200,
   parameter int unsigned         T_RP_CYC    = 3,
   parameter int unsigned         T_MRD_CYC   = 2,
   parameter int unsigned         T_RFC_CYC   = 10,
   parameter int unsigned         N_REFRESH   = 2,
   parameter int unsigned         T_DLL_CYC   = 200,
   parameter logic [2:0]          MR_BL_CODE  = 3'b011,
   parameter logic                MR_BT       = 1'b0,
   parameter logic [2:0]          MR_CL_CODE  = 3'b010,
   parameter logic [ROW_BITS-1:0] EMR_VAL     = '0,
   parameter int unsigned         CNT_W       = 16
) (
   input  logic                core_clk,
   input  logic                core_rst_sync,
`ifdef DDR_INIT_REINIT_EN
   input  logic                reinit_req,
`endif
   output logic                init_done,
   output logic                init_busy,
   output logic [3:0]          init_state,
   output logic                ddr_cke,
   output logic                ddr_cs_n,
   output logic                ddr_ras_n,
   output logic                ddr_cas_n,
   output logic                ddr_we_n,
   output logic [BA_BITS-1:0]  ddr_ba,
   output logic [ROW_BITS-1:0] ddr_a
);

   typedef enum logic [3:0] {
      S_PWRUP  = 4'd0,
      S_CKE_HI = 4'd1,
      S_PRE0   = 4'd2,
      S_EMR    = 4'd3,
      S_MRDLL  = 4'd4,
      S_PRE1   = 4'd5,
      S_REF    = 4'd6,
      S_MRRUN  = 4'd7,
      S_DLLW   = 4'd8,
      S_DONE   = 4'd9
   } state_e;

   typedef enum logic [2:0] {CMD_DESEL, CMD_NOP, CMD_PRE, CMD_LMR, CMD_REF} cmd_e;

   localparam int unsigned         REF_W      = $clog2(N_REFRESH + 1);
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]    PWRUP_LAST = CNT_W'(T_PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0]    RP_LD      = CNT_W'(T_RP_CYC - 1);
   localparam logic [CNT_W-1:0]    MRD_LD     = CNT_W'(T_MRD_CYC - 1);
   localparam logic [CNT_W-1:0]    RFC_LD     = CNT_W'(T_RFC_CYC - 1);
   localparam logic [CNT_W-1:0]    DLL_MIN    = CNT_W'(T_DLL_CYC);
   localparam logic [REF_W-1:0]    REF_ONE    = REF_W'(1);
   localparam logic [REF_W-1:0]    REF_LAST   = REF_W'(N_REFRESH);
   localparam logic [BA_BITS-1:0]  BA_EMR     = BA_BITS'(1);
   localparam logic [ROW_BITS-1:0] A_PRE_ALL  = ROW_BITS'(1024);
   // Mode register image: A8 = DLL reset, A[6:4] CAS latency, A3 burst type, A[2:0] burst length.
   localparam logic [ROW_BITS-1:0] A_MR_DLL   = ROW_BITS'({2'b10, MR_CL_CODE, MR_BT, MR_BL_CODE});
   localparam logic [ROW_BITS-1:0] A_MR_RUN   = ROW_BITS'({2'b00, MR_CL_CODE, MR_BT, MR_BL_CODE});

   state_e              state, next_state;
   logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
   logic [CNT_W-1:0]    dll_cnt, dll_cnt_nxt;
   logic [REF_W-1:0]    ref_cnt, ref_cnt_nxt;
   cmd_e                cmd_nxt;
   logic [3:0]          pins_nxt;
   logic [BA_BITS-1:0]  ba_nxt;
   logic [ROW_BITS-1:0] a_nxt;
   logic                wait_zero;
   logic                dll_met;
   logic                reinit;

`ifdef DDR_INIT_REINIT_EN
   assign reinit = reinit_req;
`else
   assign reinit = 1'b0;
`endif

   assign wait_zero  = (wait_cnt == '0);
   assign dll_met    = (dll_cnt >= DLL_MIN);
   assign init_state = state;

   // Next state, counter updates and the command to place on the bus in the next cycle.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path holds a stale value (no latch).
      next_state   = state;
      wait_cnt_nxt = wait_cnt;
      ref_cnt_nxt  = ref_cnt;
      dll_cnt_nxt  = (dll_cnt == '1) ? dll_cnt : dll_cnt + CNT_ONE;
      cmd_nxt      = CMD_NOP;
      case (state)
         S_PWRUP: begin
            if (wait_cnt >= PWRUP_LAST) begin
               next_state   = S_CKE_HI;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_ONE;
            end
         end
         S_CKE_HI: begin
            next_state   = S_PRE0;
            wait_cnt_nxt = RP_LD;
            cmd_nxt      = CMD_PRE;
         end
         S_PRE0: begin
            if (wait_zero) begin
               next_state   = S_EMR;
               wait_cnt_nxt = MRD_LD;
               cmd_nxt      = CMD_LMR;
            end else begin
               wait_cnt_nxt = wait_cnt - CNT_ONE;
            end
         end
         S_EMR: begin
            if (wait_zero) begin
               next_state   = S_MRDLL;
               wait_cnt_nxt = MRD_LD;
               dll_cnt_nxt  = CNT_ONE;  // the DLL-reset issue cycle counts as the first elapsed cycle
               cmd_nxt      = CMD_LMR;
            end else begin
               wait_cnt_nxt = wait_cnt - CNT_ONE;
            end
         end
         S_MRDLL: begin
            if (wait_zero) begin
               next_state   = S_PRE1;
               wait_cnt_nxt = RP_LD;
               cmd_nxt      = CMD_PRE;
            end else begin
               wait_cnt_nxt = wait_cnt - CNT_ONE;
            end
         end
         S_PRE1: begin
            if (wait_zero) begin
               next_state   = S_REF;
               wait_cnt_nxt = RFC_LD;
               ref_cnt_nxt  = REF_ONE;
               cmd_nxt      = CMD_REF;
            end else begin
               wait_cnt_nxt = wait_cnt - CNT_ONE;
            end
         end
         S_REF: begin
            if (!wait_zero) begin
               wait_cnt_nxt = wait_cnt - CNT_ONE;
            end else if (ref_cnt >= REF_LAST) begin
               next_state   = S_MRRUN;
               wait_cnt_nxt = MRD_LD;
               cmd_nxt      = CMD_LMR;
            end else begin
               wait_cnt_nxt = RFC_LD;
               ref_cnt_nxt  = ref_cnt + REF_ONE;
               cmd_nxt      = CMD_REF;
            end
         end
         S_MRRUN: begin
            if (!wait_zero) begin
               wait_cnt_nxt = wait_cnt - CNT_ONE;
            end else begin
               next_state = dll_met ? S_DONE : S_DLLW;
            end
         end
         S_DLLW: begin
            if (dll_met) next_state = S_DONE;
         end
         S_DONE: begin
            if (reinit) begin
               next_state   = S_PRE0;
               wait_cnt_nxt = RP_LD;
               ref_cnt_nxt  = '0;
               cmd_nxt      = CMD_PRE;
            end
         end
         default: begin
            next_state   = S_PWRUP;
            wait_cnt_nxt = '0;
            ref_cnt_nxt  = '0;
         end
      endcase

      // CKE is low only in PWRUP, where idle cycles are DESELECT rather than NOP.
      if (next_state == S_PWRUP) cmd_nxt = CMD_DESEL;

      ba_nxt = '0;
      a_nxt  = '0;
      if (cmd_nxt == CMD_PRE) begin
         a_nxt = A_PRE_ALL;
      end else if (cmd_nxt == CMD_LMR) begin
         case (next_state)
            S_EMR: begin
               ba_nxt = BA_EMR;
               a_nxt  = EMR_VAL;
            end
            S_MRDLL: a_nxt = A_MR_DLL;
            default: a_nxt = A_MR_RUN;
         endcase
      end

      case (cmd_nxt)
         CMD_NOP: pins_nxt = 4'b0111;
         CMD_PRE: pins_nxt = 4'b0010;
         CMD_LMR: pins_nxt = 4'b0000;
         CMD_REF: pins_nxt = 4'b0001;
         default: pins_nxt = 4'b1111;
      endcase
   end

   // State, counters and registered DDR bus / status outputs.
   always_ff @(posedge core_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of order.
      if (core_rst_sync) begin
         state     <= S_PWRUP;
         wait_cnt  <= '0;
         dll_cnt   <= '0;
         ref_cnt   <= '0;
         ddr_cke   <= 1'b0;
         ddr_cs_n  <= 1'b1;
         ddr_ras_n <= 1'b1;
         ddr_cas_n <= 1'b1;
         ddr_we_n  <= 1'b1;
         ddr_ba    <= '0;
         ddr_a     <= '0;
         init_done <= 1'b0;
         init_busy <= 1'b1;
      end else begin
         state     <= next_state;
         wait_cnt  <= wait_cnt_nxt;
         dll_cnt   <= dll_cnt_nxt;
         ref_cnt   <= ref_cnt_nxt;
         ddr_cke   <= (next_state != S_PWRUP);
         {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} <= pins_nxt;
         ddr_ba    <= ba_nxt;
         ddr_a     <= a_nxt;
         init_done <= (next_state == S_DONE);
         init_busy <= (next_state != S_DONE);
      end
   end

endmodule

// File: tb/tb_ddr_init_seq.sv
// tb_ddr_init_seq: directed bench for ddr_init_seq.
// u_a uses the nominal short timings; u_b adds N_REFRESH=4 and T_DLL_CYC=1.
// Cycle 0 is the clock period right after reset is released.
`timescale 1ns/1ps
module tb_ddr_init_seq;

   localparam logic [3:0] P_DESEL = 4'hF;
   localparam logic [3:0] P_NOP   = 4'h7;
   localparam logic [3:0] P_PRE   = 4'h2;
   localparam logic [3:0] P_LMR   = 4'h0;
   localparam logic [3:0] P_REF   = 4'h1;

   typedef struct {
      int         cyc;
      logic [3:0] pins;
      logic [1:0] ba;
      logic [12:0] a;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic reinit = 1'b0;

   logic ua_done, ua_busy, ua_cke, ua_cs, ua_ras, ua_cas, ua_we;
   logic [3:0] ua_state;
   logic [1:0] ua_ba;
   logic [12:0] ua_a;
   logic ub_done, ub_busy, ub_cke, ub_cs, ub_ras, ub_cas, ub_we;
   logic [3:0] ub_state;
   logic [1:0] ub_ba;
   logic [12:0] ub_a;

   int n_vec = 0;
   int n_err = 0;
   cmd_t ua_q[$];
   cmd_t ub_q[$];

   always #5 clk = ~clk;

   ddr_init_seq #(
      .ROW_BITS(13), .BA_BITS(2), .T_PWRUP_CYC(8), .T_RP_CYC(3), .T_MRD_CYC(2),
      .T_RFC_CYC(5), .N_REFRESH(2), .T_DLL_CYC(20)
   ) u_a (
      .core_clk(clk), .core_rst_sync(rst),
`ifdef DDR_INIT_REINIT_EN
      .reinit_req(reinit),
`endif
      .init_done(ua_done), .init_busy(ua_busy), .init_state(ua_state), .ddr_cke(ua_cke),
      .ddr_cs_n(ua_cs), .ddr_ras_n(ua_ras), .ddr_cas_n(ua_cas), .ddr_we_n(ua_we),
      .ddr_ba(ua_ba), .ddr_a(ua_a)
   );

   ddr_init_seq #(
      .ROW_BITS(13), .BA_BITS(2), .T_PWRUP_CYC(8), .T_RP_CYC(3), .T_MRD_CYC(2),
      .T_RFC_CYC(5), .N_REFRESH(4), .T_DLL_CYC(1)
   ) u_b (
      .core_clk(clk), .core_rst_sync(rst),
`ifdef DDR_INIT_REINIT_EN
      .reinit_req(1'b0),
`endif
      .init_done(ub_done), .init_busy(ub_busy), .init_state(ub_state), .ddr_cke(ub_cke),
      .ddr_cs_n(ub_cs), .ddr_ras_n(ub_ras), .ddr_cas_n(ub_cas), .ddr_we_n(ub_we),
      .ddr_ba(ub_ba), .ddr_a(ub_a)
   );

   function automatic cmd_t mk(input int cyc, input logic [3:0] pins, input logic [1:0] ba,
                               input logic [12:0] a);
      cmd_t c;
      c.cyc  = cyc;
      c.pins = pins;
      c.ba   = ba;
      c.a    = a;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for four edges and release; returns in cycle 0.
   task automatic do_reset();
      rst = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
   endtask

   // Checks cycles 0..9 after a release: 8 DESELECT cycles with CKE low, CKE-high NOP, then PRE all.
   task automatic test_powerup();
      int bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) tick();
         if (c < 8) begin
            if (ua_cke !== 1'b0 || {ua_cs, ua_ras, ua_cas, ua_we} !== P_DESEL || ua_ba !== 2'd0 ||
                ua_a !== 13'd0 || ua_done !== 1'b0 || ua_busy !== 1'b1 || ua_state !== 4'd0) bad++;
         end else if (c == 8) begin
            n_vec++;
            if (ua_cke !== 1'b1 || {ua_cs, ua_ras, ua_cas, ua_we} !== P_NOP) begin
               n_err++;
               $display("FAIL cke_hi: cke=%b pins=%h, want cke=1 pins=%h", ua_cke,
                        {ua_cs, ua_ras, ua_cas, ua_we}, P_NOP);
            end
         end else begin
            n_vec++;
            if (ua_cke !== 1'b1 || {ua_cs, ua_ras, ua_cas, ua_we} !== P_PRE || ua_a[10] !== 1'b1) begin
               n_err++;
               $display("FAIL first_pre: cke=%b pins=%h a=%h, want cke=1 pins=%h a[10]=1", ua_cke,
                        {ua_cs, ua_ras, ua_cas, ua_we}, ua_a, P_PRE);
            end
         end
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL pwrup_deselect: %0d bad cycles, want 0", bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_vec++;
      if (ua_cke !== 1'b0 || {ua_cs, ua_ras, ua_cas, ua_we} !== P_DESEL || ua_ba !== 2'd0 ||
          ua_a !== 13'd0 || ua_done !== 1'b0 || ua_busy !== 1'b1 || ua_state !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state: cke=%b pins=%h ba=%h a=%h done=%b busy=%b st=%0d, want 0 f 0 0 0 1 0",
                  ua_cke, {ua_cs, ua_ras, ua_cas, ua_we}, ua_ba, ua_a, ua_done, ua_busy, ua_state);
      end
      repeat (3) tick();
      rst = 1'b0;
      test_powerup();
   endtask

   task automatic test_full_run();
      cmd_t ea[$];
      cmd_t eb[$];
      int a_done = -1;
      int b_done = -1;
      int a_bad = 0;
      int b_bad = 0;
      logic [3:0] pa, pb;
      ua_q.delete();
      ub_q.delete();
      ea.push_back(mk(9, P_PRE, 2'd0, 13'h400));
      ea.push_back(mk(12, P_LMR, 2'd1, 13'h000));
      ea.push_back(mk(14, P_LMR, 2'd0, 13'h123));
      ea.push_back(mk(16, P_PRE, 2'd0, 13'h400));
      ea.push_back(mk(19, P_REF, 2'd0, 13'h000));
      ea.push_back(mk(24, P_REF, 2'd0, 13'h000));
      ea.push_back(mk(29, P_LMR, 2'd0, 13'h023));
      for (int i = 0; i < 6; i++) eb.push_back(ea[i]);
      eb.push_back(mk(29, P_REF, 2'd0, 13'h000));
      eb.push_back(mk(34, P_REF, 2'd0, 13'h000));
      eb.push_back(mk(39, P_LMR, 2'd0, 13'h023));
      do_reset();
      for (int c = 0; c < 60; c++) begin
         if (c > 0) tick();
         pa = {ua_cs, ua_ras, ua_cas, ua_we};
         pb = {ub_cs, ub_ras, ub_cas, ub_we};
         if (pa !== P_NOP && pa !== P_DESEL) ua_q.push_back(mk(c, pa, ua_ba, ua_a));
         else if (ua_ba !== 2'd0 || ua_a !== 13'd0) a_bad++;
         if (pb !== P_NOP && pb !== P_DESEL) ub_q.push_back(mk(c, pb, ub_ba, ub_a));
         else if (ub_ba !== 2'd0 || ub_a !== 13'd0) b_bad++;
         if (ua_done === 1'b1 && a_done < 0) a_done = c;
         if (ub_done === 1'b1 && b_done < 0) b_done = c;
         if (a_done >= 0 && (ua_done !== 1'b1 || ua_busy !== 1'b0 || ua_cke !== 1'b1 ||
                             pa !== P_NOP || ua_state !== 4'd9)) a_bad++;
         if (a_done < 0 && (ua_done !== 1'b0 || ua_busy !== 1'b1)) a_bad++;
         if (b_done >= 0 && (ub_done !== 1'b1 || ub_busy !== 1'b0 || ub_cke !== 1'b1 ||
                             pb !== P_NOP || ub_state !== 4'd9)) b_bad++;
         if (b_done < 0 && (ub_done !== 1'b0 || ub_busy !== 1'b1)) b_bad++;
      end
      n_vec++;
      if (ua_q.size() != ea.size()) begin
         n_err++;
         $display("FAIL a_cmd_count: %0d commands, want %0d", ua_q.size(), ea.size());
      end
      for (int i = 0; i < ea.size(); i++) begin
         n_vec++;
         if (i >= ua_q.size()) begin
            n_err++;
            $display("FAIL a_cmd%0d: missing, want cyc=%0d pins=%h", i, ea[i].cyc, ea[i].pins);
         end else if (ua_q[i].cyc != ea[i].cyc || ua_q[i].pins !== ea[i].pins ||
                      ua_q[i].ba !== ea[i].ba || ua_q[i].a !== ea[i].a) begin
            n_err++;
            $display("FAIL a_cmd%0d: cyc=%0d pins=%h ba=%h a=%h, want cyc=%0d pins=%h ba=%h a=%h", i,
                     ua_q[i].cyc, ua_q[i].pins, ua_q[i].ba, ua_q[i].a,
                     ea[i].cyc, ea[i].pins, ea[i].ba, ea[i].a);
         end
      end
      n_vec++;
      if (ub_q.size() != eb.size()) begin
         n_err++;
         $display("FAIL b_cmd_count: %0d commands, want %0d", ub_q.size(), eb.size());
      end
      for (int i = 0; i < eb.size(); i++) begin
         n_vec++;
         if (i >= ub_q.size()) begin
            n_err++;
            $display("FAIL b_cmd%0d: missing, want cyc=%0d pins=%h", i, eb[i].cyc, eb[i].pins);
         end else if (ub_q[i].cyc != eb[i].cyc || ub_q[i].pins !== eb[i].pins ||
                      ub_q[i].ba !== eb[i].ba || ub_q[i].a !== eb[i].a) begin
            n_err++;
            $display("FAIL b_cmd%0d: cyc=%0d pins=%h ba=%h a=%h, want cyc=%0d pins=%h ba=%h a=%h", i,
                     ub_q[i].cyc, ub_q[i].pins, ub_q[i].ba, ub_q[i].a,
                     eb[i].cyc, eb[i].pins, eb[i].ba, eb[i].a);
         end
      end
      // DLL-reset LMR at 14, T_DLL_CYC=20 -> DONE at 34.
      n_vec++;
      if (a_done != 34) begin
         n_err++;
         $display("FAIL a_dll_gate: init_done at cycle %0d, want 34", a_done);
      end
      // MRRUN at 39, its wait expires at 40 -> DONE at 41 with no DLLW cycles.
      n_vec++;
      if (b_done != 41) begin
         n_err++;
         $display("FAIL b_dll_met: init_done at cycle %0d, want 41", b_done);
      end
      n_vec++;
      if (a_bad != 0) begin
         n_err++;
         $display("FAIL a_idle_bus: %0d bad cycles, want 0", a_bad);
      end
      n_vec++;
      if (b_bad != 0) begin
         n_err++;
         $display("FAIL b_idle_bus: %0d bad cycles, want 0", b_bad);
      end
   endtask

`ifdef DDR_INIT_REINIT_EN
   task automatic test_reinit();
      int done_c = -1;
      int cke_bad = 0;
      int got[$];
      int exp_c[6] = '{3, 5, 7, 10, 15, 20};
      logic [3:0] p;
      n_vec++;
      if (ua_done !== 1'b1 || ua_state !== 4'd9) begin
         n_err++;
         $display("FAIL reinit_pre: done=%b st=%0d, want 1 9", ua_done, ua_state);
      end
      reinit = 1'b1;
      tick();
      reinit = 1'b0;
      p = {ua_cs, ua_ras, ua_cas, ua_we};
      n_vec++;
      if (ua_done !== 1'b0 || ua_busy !== 1'b1 || ua_cke !== 1'b1 || p !== P_PRE ||
          ua_a[10] !== 1'b1 || ua_state !== 4'd2) begin
         n_err++;
         $display("FAIL reinit_start: done=%b busy=%b cke=%b pins=%h a=%h st=%0d, want 0 1 1 2 400 2",
                  ua_done, ua_busy, ua_cke, p, ua_a, ua_state);
      end
      for (int r = 1; r <= 40; r++) begin
         tick();
         p = {ua_cs, ua_ras, ua_cas, ua_we};
         if (p !== P_NOP && p !== P_DESEL) got.push_back(r);
         if (ua_done === 1'b1 && done_c < 0) done_c = r;
         if (ua_cke !== 1'b1) cke_bad++;
         if (r == 11) begin
            n_vec++;
            if (ua_state !== 4'd6) begin
               n_err++;
               $display("FAIL reinit_ref_wait: st=%0d, want 6", ua_state);
            end
         end
         reinit = (r == 11);
      end
      n_vec++;
      if (got.size() != 6) begin
         n_err++;
         $display("FAIL reinit_cmd_count: %0d commands, want 6", got.size());
      end
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if (i >= got.size() || got[i] != exp_c[i]) begin
            n_err++;
            $display("FAIL reinit_cmd%0d: cyc=%0d, want %0d", i, (i < got.size()) ? got[i] : -1, exp_c[i]);
         end
      end
      n_vec++;
      if (done_c != 25) begin
         n_err++;
         $display("FAIL reinit_done: init_done at %0d, want 25", done_c);
      end
      n_vec++;
      if (cke_bad != 0) begin
         n_err++;
         $display("FAIL reinit_cke: %0d cycles with cke low, want 0", cke_bad);
      end
   endtask
`endif

   // Reset asserted during the second REF wait aborts and replays the power-up sequence.
   task automatic test_mid_reset();
      do_reset();
      repeat (26) tick();
      n_vec++;
      if (ua_state !== 4'd6 || {ua_cs, ua_ras, ua_cas, ua_we} !== P_NOP) begin
         n_err++;
         $display("FAIL mid_pre: st=%0d pins=%h, want 6 7", ua_state, {ua_cs, ua_ras, ua_cas, ua_we});
      end
      rst = 1'b1;
      tick();
      n_vec++;
      if (ua_cke !== 1'b0 || {ua_cs, ua_ras, ua_cas, ua_we} !== P_DESEL || ua_done !== 1'b0 ||
          ua_busy !== 1'b1 || ua_state !== 4'd0) begin
         n_err++;
         $display("FAIL mid_reset: cke=%b pins=%h done=%b busy=%b st=%0d, want 0 f 0 1 0",
                  ua_cke, {ua_cs, ua_ras, ua_cas, ua_we}, ua_done, ua_busy, ua_state);
      end
      repeat (3) tick();
      rst = 1'b0;
      test_powerup();
   endtask

   initial begin
      test_reset();
      test_full_run();
`ifdef DDR_INIT_REINIT_EN
      test_reinit();
`endif
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
